// File: rtl/l15_req_arbiter_pkg.sv
// Shared definitions for the L1.5 request arbiter: source port indices,
// port-id type and arbiter FSM states.
package l15_req_arbiter_pkg;

    localparam int NUM_PORTS = 6;

    localparam int ICACHE    = 0;
    localparam int DCACHE    = 1;
    localparam int WBUF      = 2;
    localparam int UNC_READ  = 3;
    localparam int UNC_WRITE = 4;
    localparam int AMO       = 5;

    typedef logic [$clog2(NUM_PORTS)-1:0] req_portid_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/l15_credit_counter.sv
// Per-port outstanding-request counter: counts L1.5 header acks up and
// L1.5 returns down, flags returns that arrive with nothing outstanding.
module l15_credit_counter #(
    parameter  int MaxOutstanding = 4,
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            rtrn,
    output logic [CntW-1:0] cnt_next,
    output logic            has_credit,
    output logic            err
);

    logic [CntW-1:0] cnt;
    logic            dec;

    always_comb begin
        dec        = rtrn && (cnt != '0);
        err        = rtrn && (cnt == '0);
        cnt_next   = cnt + CntW'(inc) - CntW'(dec);
        has_credit = int'(cnt_next) < MaxOutstanding;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/l15_req_arbiter.sv
// Fixed-priority arbiter in front of the L1.5 request port with per-port
// credit tracking. Define L15_REQ_ARB_STARVE_GUARD_EN to add age-based
// starvation override.
//
// state | meaning
// IDLE  | no request presented to L1.5; grant combinationally if any port eligible
// HOLD  | l15_val_o high with latched payload/portid until header ack
module l15_req_arbiter
    import l15_req_arbiter_pkg::*;
#(
    parameter int NumPorts       = 6,
    parameter int PayloadWidth   = 128,
    parameter int MaxOutstanding = 4,
    parameter int StarveLimit    = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumPorts-1:0]              req_valid_i,
    output logic [NumPorts-1:0]              req_ready_o,
    input  logic [NumPorts*PayloadWidth-1:0] req_payload_i,
    output logic                             l15_val_o,
    output logic [PayloadWidth-1:0]          l15_payload_o,
    output logic [$clog2(NumPorts)-1:0]      l15_portid_o,
    input  logic                             l15_header_ack_i,
    input  logic                             rtrn_val_i,
    input  logic [$clog2(NumPorts)-1:0]      rtrn_portid_i,
    output logic                             credit_err_o,
    output logic                             busy_o
);

    localparam int PidW = $clog2(NumPorts);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    if (MaxOutstanding < 1 || StarveLimit < 1) begin : g_bad_cfg
        $error("l15_req_arbiter: MaxOutstanding and StarveLimit must be >= 1");
    end

    arb_state_t                     state;
    logic [NumPorts-1:0]            has_credit;
    logic [NumPorts-1:0]            cnt_err;
    logic [NumPorts-1:0][CntW-1:0]  cnt_next;
    logic [NumPorts-1:0]            elig;
    logic [NumPorts-1:0]            pick;
    logic [PidW-1:0]                gnt_idx;
    logic [PayloadWidth-1:0]        gnt_payload;
    logic                           any_elig;
    logic                           arb_en;
    logic                           hold_next;
    logic                           busy_next;
    logic                           pid_bad;

    for (genvar p = 0; p < NumPorts; p++) begin : g_cnt
        l15_credit_counter #(
            .MaxOutstanding(MaxOutstanding)
        ) u_cnt (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .inc        ((state == HOLD) && l15_header_ack_i && (l15_portid_o == PidW'(p))),
            .rtrn       (rtrn_val_i && (rtrn_portid_i == PidW'(p))),
            .cnt_next   (cnt_next[p]),
            .has_credit (has_credit[p]),
            .err        (cnt_err[p])
        );
    end

    assign elig     = req_valid_i & has_credit;
    assign any_elig = |elig;
    // Re-arbitration happens in IDLE and on the ack cycle of HOLD.
    assign arb_en   = (state == IDLE) || l15_header_ack_i;
    assign pid_bad  = rtrn_val_i && (32'(rtrn_portid_i) >= NumPorts);

`ifdef L15_REQ_ARB_STARVE_GUARD_EN
    localparam int AgeW = $clog2(StarveLimit + 1);

    logic [NumPorts-1:0][AgeW-1:0] age;
    logic [NumPorts-1:0]           starved;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            starved[p] = elig[p] && (age[p] == AgeW'(StarveLimit));
        end
        pick = (|starved) ? starved : elig;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (!req_valid_i[p] || req_ready_o[p]) begin
                    age[p] <= '0;
                end else if (elig[p] && (age[p] != AgeW'(StarveLimit))) begin
                    age[p] <= age[p] + AgeW'(1);
                end
            end
        end
    end
`else
    assign pick = elig;
`endif

    always_comb begin
        gnt_idx = '0;
        for (int p = NumPorts - 1; p >= 0; p--) begin
            if (pick[p]) begin
                gnt_idx = PidW'(p);
            end
        end
        gnt_payload = req_payload_i[int'(gnt_idx) * PayloadWidth +: PayloadWidth];
        req_ready_o = (rst_ni && arb_en && any_elig) ? (NumPorts'(1) << gnt_idx) : '0;
        hold_next   = arb_en ? any_elig : 1'b1;
        busy_next   = hold_next;
        for (int p = 0; p < NumPorts; p++) begin
            busy_next = busy_next || (cnt_next[p] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            l15_val_o     <= 1'b0;
            l15_payload_o <= '0;
            l15_portid_o  <= '0;
            credit_err_o  <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            busy_o <= busy_next;
            if (pid_bad || (|cnt_err)) begin
                credit_err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state         <= HOLD;
                        l15_val_o     <= 1'b1;
                        l15_payload_o <= gnt_payload;
                        l15_portid_o  <= gnt_idx;
                    end
                end
                HOLD: begin
                    if (l15_header_ack_i) begin
                        if (any_elig) begin
                            l15_payload_o <= gnt_payload;
                            l15_portid_o  <= gnt_idx;
                        end else begin
                            state     <= IDLE;
                            l15_val_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    l15_val_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
